// File: rtl/vote_pkg.sv
// Shared types and width helpers for the vote tally engine and its counters.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_TALLY = 2'd2,
        ST_DONE  = 2'd3
    } poll_state_t;

    localparam int STATE_W = 2;

    // Candidate index width; never below 1 so a single-candidate build still has a port.
    function automatic int idx_w(input int num_cand);
        return (num_cand > 1) ? $clog2(num_cand) : 1;
    endfunction

    // Wide enough for every counter saturated at once, so the sum never wraps.
    function automatic int total_w(input int num_cand, input int cnt_w);
        return cnt_w + $clog2(num_cand);
    endfunction

endpackage

// File: rtl/vote_counter_sat.sv
// Per-candidate saturating vote counter; clr wins over inc, reset wins over both.
module vote_counter_sat
    import vote_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !at_max) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign at_max = &count_q;
    assign count  = count_q;

endmodule

// File: rtl/vote_tally_engine.sv
// Poll session FSM with one-hot vote validation, saturating per-candidate counts
// and a one-candidate-per-cycle winner/tie scan when the poll closes.
module vote_tally_engine
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 open_poll,
    input  logic                                 close_poll,
    input  logic [NUM_CAND-1:0]                  vote_valid,
    output logic                                 vote_accept,
    output logic                                 vote_reject,
    output logic [NUM_CAND*CNT_W-1:0]            count_flat,
    output logic [total_w(NUM_CAND, CNT_W)-1:0]  total_votes,
    output logic [STATE_W-1:0]                   poll_state,
    output logic                                 sat_flag,
    output logic                                 result_valid,
    output logic [idx_w(NUM_CAND)-1:0]           winner_idx,
    output logic                                 tie
);

    localparam int IDX_W  = idx_w(NUM_CAND);
    localparam int TOT_W  = total_w(NUM_CAND, CNT_W);
    localparam int SCAN_W = IDX_W + 1;

    poll_state_t       state_q;
    logic              vote_accept_q;
    logic              vote_reject_q;
    logic [TOT_W-1:0]  total_q;
    logic              sat_q;
    logic              result_valid_q;
    logic [IDX_W-1:0]  winner_q;
    logic              tie_q;
    logic [CNT_W-1:0]  max_q;
    logic [SCAN_W-1:0] scan_idx_q;

    logic [CNT_W-1:0]    cnt [NUM_CAND];
    logic [NUM_CAND-1:0] at_max_vec;
    logic [NUM_CAND-1:0] inc_vec;
    logic                is_open;
    logic                one_hot;
    logic                hit_max;
    logic                do_accept;
    logic                do_sat;
    logic                do_reject;
    logic                clr_counts;
    logic                scan_done;
    logic [CNT_W-1:0]    cur_cnt;

    // A vote is only counted for exactly one bit set; multi-bit ballots are refused outright.
    assign is_open    = (state_q == ST_OPEN);
    assign one_hot    = ($countones(vote_valid) == 1);
    assign hit_max    = |(vote_valid & at_max_vec);
    assign do_accept  = is_open && one_hot && !hit_max;
    assign do_sat     = is_open && one_hot && hit_max;
    assign do_reject  = (|vote_valid) && !do_accept;
    assign inc_vec    = do_accept ? vote_valid : '0;
    assign clr_counts = open_poll && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign scan_done  = (scan_idx_q == SCAN_W'(NUM_CAND));
    assign cur_cnt    = cnt[scan_idx_q[IDX_W-1:0]];

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
        vote_counter_sat #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .clr    (clr_counts),
            .inc    (inc_vec[i]),
            .count  (cnt[i]),
            .at_max (at_max_vec[i])
        );
        assign count_flat[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            vote_accept_q  <= 1'b0;
            vote_reject_q  <= 1'b0;
            total_q        <= '0;
            sat_q          <= 1'b0;
            result_valid_q <= 1'b0;
            winner_q       <= '0;
            tie_q          <= 1'b0;
            max_q          <= '0;
            scan_idx_q     <= '0;
        end else begin
            vote_accept_q <= do_accept;
            vote_reject_q <= do_reject;
            if (do_accept) begin
                total_q <= total_q + TOT_W'(1);
            end
            if (do_sat) begin
                sat_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (open_poll) begin
                        state_q <= ST_OPEN;
                        total_q <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (close_poll) begin
                        state_q    <= ST_TALLY;
                        scan_idx_q <= '0;
                    end
                end
                ST_TALLY: begin
                    // Candidate 0 seeds the running max; later equals only raise tie.
                    if (scan_done) begin
                        state_q        <= ST_DONE;
                        result_valid_q <= 1'b1;
                    end else begin
                        scan_idx_q <= scan_idx_q + SCAN_W'(1);
                        if (scan_idx_q == '0) begin
                            max_q    <= cur_cnt;
                            winner_q <= '0;
                            tie_q    <= 1'b0;
                        end else if (cur_cnt > max_q) begin
                            max_q    <= cur_cnt;
                            winner_q <= scan_idx_q[IDX_W-1:0];
                            tie_q    <= 1'b0;
                        end else if (cur_cnt == max_q) begin
                            tie_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (open_poll) begin
                        state_q        <= ST_OPEN;
                        result_valid_q <= 1'b0;
                        total_q        <= '0;
                        sat_q          <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vote_accept  = vote_accept_q;
    assign vote_reject  = vote_reject_q;
    assign total_votes  = total_q;
    assign poll_state   = state_q;
    assign sat_flag     = sat_q;
    assign result_valid = result_valid_q;
    assign winner_idx   = winner_q;
    assign tie          = tie_q;

endmodule
